// File: rtl/alu_sched_if.sv
// alu_sched_if: requester-side request/response channels plus the shared-ALU port of alu_sched.
// master = requester/ALU side, slave = scheduler side.
interface alu_sched_if #(
  parameter int unsigned NREQ = 4
);
  localparam int unsigned DW = 32;
  localparam int unsigned OW = 4;
  localparam int unsigned RW = 64;

  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*DW-1:0]   req_a;
  logic [NREQ*DW-1:0]   req_b;
  logic [NREQ*OW-1:0]   req_op;
  logic [NREQ-1:0]      resp_valid;
  logic [NREQ-1:0]      resp_ready;
  logic [RW-1:0]        resp_data;
  logic                 resp_err;
  logic [DW-1:0]        alu_a;
  logic [DW-1:0]        alu_b;
  logic [OW-1:0]        alu_sel;
  logic [RW-1:0]        alu_out;
  logic                 busy;

  modport master (
    output req_valid, req_a, req_b, req_op, resp_ready, alu_out,
    input  req_ready, resp_valid, resp_data, resp_err, alu_a, alu_b, alu_sel, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, resp_ready, alu_out,
    output req_ready, resp_valid, resp_data, resp_err, alu_a, alu_b, alu_sel, busy
  );
endinterface

// File: rtl/alu_sched.sv
// alu_sched: round-robin scheduler sharing one registered 32-bit ALU among NREQ requesters.
// Define ALU_SCHED_OPCHECK_EN to screen illegal ops in IDLE and answer them without using the ALU.
module alu_sched #(
  parameter int unsigned NREQ = 4
) (
  input  logic       clk,
  input  logic       rst,
  alu_sched_if.slave bus
);
  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned DW = 32;
  localparam int unsigned OW = 4;
  localparam int unsigned RW = 64;

`ifdef ALU_SCHED_OPCHECK_EN
  localparam bit OPCHECK_EN = 1'b1;
`else
  localparam bit OPCHECK_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   gnt;
  logic [DW-1:0]   alu_a_q;
  logic [DW-1:0]   alu_b_q;
  logic [OW-1:0]   alu_sel_q;
  logic [RW-1:0]   resp_data_q;
  logic            resp_err_q;
  logic [NREQ-1:0] resp_valid_q;
  logic [NREQ-1:0] resp_valid_d;
  logic            busy_q;

  logic            accept;
  logic            load_result;

  // Per-requester views of the flat operand buses
  logic [NREQ-1:0][DW-1:0] a_arr;
  logic [NREQ-1:0][DW-1:0] b_arr;
  logic [NREQ-1:0][OW-1:0] op_arr;

  assign a_arr  = bus.req_a;
  assign b_arr  = bus.req_b;
  assign op_arr = bus.req_op;

  logic            grant_found;
  logic [IW-1:0]   grant_idx;
  logic [IW-1:0]   ptr_next;
  logic [DW-1:0]   sel_a;
  logic [DW-1:0]   sel_b;
  logic [OW-1:0]   sel_op;
  logic            op_illegal;

  // First valid requester at or after rr_ptr, wrapping modulo NREQ
  always_comb begin : rr_search
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!grant_found && bus.req_valid[IW'((32'(rr_ptr) + k) % NREQ)]) begin
        grant_found = 1'b1;
        grant_idx   = IW'((32'(rr_ptr) + k) % NREQ);
      end
    end
  end

  assign ptr_next = IW'((32'(grant_idx) + 32'd1) % NREQ);
  assign sel_a    = a_arr[grant_idx];
  assign sel_b    = b_arr[grant_idx];
  assign sel_op   = op_arr[grant_idx];

  // Reserved opcode, or divide by zero
  assign op_illegal = OPCHECK_EN &&
                      ((sel_op == 4'b1111) || ((sel_op == 4'b0011) && (sel_b == '0)));

  always_comb begin : fsm_next
    state_d      = state_q;
    accept       = 1'b0;
    load_result  = 1'b0;
    resp_valid_d = resp_valid_q;
    unique case (state_q)
      IDLE: begin
        if (grant_found) begin
          accept = 1'b1;
          if (op_illegal) begin
            state_d      = RESP;
            resp_valid_d = NREQ'(1) << grant_idx;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        state_d      = RESP;
        load_result  = 1'b1;
        resp_valid_d = NREQ'(1) << gnt;
      end
      RESP: begin
        if (bus.resp_ready[gnt]) begin
          state_d      = IDLE;
          resp_valid_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin : regs
    if (rst) begin
      state_q      <= IDLE;
      rr_ptr       <= '0;
      gnt          <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_sel_q    <= '0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
      resp_valid_q <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      busy_q       <= (state_d != IDLE);
      resp_valid_q <= resp_valid_d;
      if (accept) begin
        gnt    <= grant_idx;
        rr_ptr <= ptr_next;
        // Illegal ops bypass the ALU, so its inputs keep their last values
        if (op_illegal) begin
          resp_data_q <= '0;
          resp_err_q  <= 1'b1;
        end else begin
          alu_a_q   <= sel_a;
          alu_b_q   <= sel_b;
          alu_sel_q <= sel_op;
        end
      end
      if (load_result) begin
        resp_data_q <= bus.alu_out;
        resp_err_q  <= 1'b0;
      end
    end
  end

  // Accept strobe is combinational in IDLE so a request is taken the cycle it is seen
  assign bus.req_ready  = (state_q == IDLE && !rst && grant_found) ? (NREQ'(1) << grant_idx) : '0;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.alu_sel    = alu_sel_q;
  assign bus.busy       = busy_q;

endmodule
